// File: rtl/jcnt_if.sv
// jcnt_if: command/status bundle between a sequencer master and jcnt_seq_ctrl (commands in, counter pattern/phase/status out)
interface jcnt_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int PH_W  = $clog2(2 * WIDTH)
);
  logic             start, dir, pause, abort, load, busy, done, err;
  logic [CNT_W-1:0] steps;
  logic [WIDTH-1:0] load_val, q;
  logic [PH_W-1:0]  phase;
  modport master (output start, steps, dir, pause, abort, load, load_val, input q, phase, busy, done, err);
  modport slave  (input start, steps, dir, pause, abort, load, load_val, output q, phase, busy, done, err);
endinterface

// File: rtl/jcnt_seq_ctrl.sv
// jcnt_seq_ctrl: Johnson-counter step sequencer; clk, rst (sync active-low), bus: start/steps/dir/pause/abort/load/load_val in, q/phase/busy/done/err out
module jcnt_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int PH_W  = $clog2(2 * WIDTH)
) (
  input logic   clk,
  input logic   rst,
  jcnt_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t           state, state_d;
  logic [WIDTH-1:0] q, q_d;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] rem, rem_d;
  logic             dir_q, dir_d, err, err_d, done, done_d;
  function automatic logic legal(input logic [WIDTH-1:0] v);
    logic [WIDTH-2:0] t;
    t = v[WIDTH-2:0] ^ v[WIDTH-1:1];
    return (t & (t - 1'b1)) == '0;
  endfunction
  function automatic logic [PH_W-1:0] ph(input logic [WIDTH-1:0] v);
    logic [PH_W:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c += {{PH_W{1'b0}}, v[i]};
    return v[WIDTH-1] ? PH_W'(2 * WIDTH - 32'(c)) : PH_W'(c);
  endfunction
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic rev);
    return rev ? {~v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], ~v[WIDTH-1]};
  endfunction
  always_comb begin
    state_d = state;
    q_d     = q;
    rem_d   = rem;
    dir_d   = dir_q;
    err_d   = err;
    done_d  = 1'b0;
    unique case (state)
      IDLE:
        if (bus.load) begin
          q_d   = legal(bus.load_val) ? bus.load_val : q;
          err_d = !legal(bus.load_val);
        end else if (bus.start) begin
          if (bus.steps != '0) begin
            rem_d   = bus.steps;
            dir_d   = bus.dir;
            err_d   = 1'b0;
            state_d = RUN;
          end else done_d = 1'b1;
        end
      RUN:
        if (bus.abort) state_d = IDLE;
        else if (bus.pause) state_d = PAUSE;
        else begin
          q_d   = step(q, dir_q);
          rem_d = rem - 1'b1;
          if (rem == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      PAUSE: state_d = bus.abort ? IDLE : bus.pause ? PAUSE : RUN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      q     <= '0;
      phase <= '0;
      rem   <= '0;
      dir_q <= 1'b0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      q     <= q_d;
      phase <= ph(q_d);
      rem   <= rem_d;
      dir_q <= dir_d;
      err   <= err_d;
      done  <= done_d;
    end
  assign bus.q     = q;
  assign bus.phase = phase;
  assign bus.busy  = state != IDLE;
  assign bus.done  = done;
  assign bus.err   = err;
endmodule

// File: tb/tb_jcnt_seq_ctrl.sv
// tb_jcnt_seq_ctrl: vector table, directed multi-cycle sequences and random stimulus against a phase-index reference model
module tb_jcnt_seq_ctrl;
  localparam int W = 4;
  logic clk, rst;
  int n_chk = 0, n_fail = 0, cyc_n = 0, t0;
  int mp, mode, mrem;
  logic mdir, mdone, merr;
  typedef struct {
    logic rst, start;
    logic [7:0] steps;
    logic dir, pause, abort, load;
    logic [3:0] lv, q;
    logic [2:0] ph;
    logic busy, done, err;
  } vec_t;
  vec_t tbl[$];
  jcnt_if b();
  jcnt_seq_ctrl dut (.clk(clk), .rst(rst), .bus(b));
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [W-1:0] pat(input int p);
    logic [W-1:0] all;
    all = '1;
    return p < W ? all >> (W - p) : all << (p - W);
  endfunction
  function automatic int find(input logic [W-1:0] v);
    for (int k = 0; k < 2 * W; k++) if (pat(k) == v) return k;
    return -1;
  endfunction
  function automatic logic [15:0] outs();
    return 16'({b.q, b.phase, b.busy, b.done, b.err});
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model_step();
    int k;
    if (!rst) begin
      mp = 0; mode = 0; mrem = 0; merr = 0; mdone = 0;
    end else begin
      mdone = 0;
      if (mode == 0) begin
        if (b.load) begin
          k = find(b.load_val);
          if (k >= 0) begin mp = k; merr = 0; end else merr = 1;
        end else if (b.start) begin
          if (b.steps != 0) begin mrem = int'(b.steps); mdir = b.dir; merr = 0; mode = 1; end
          else mdone = 1;
        end
      end else if (b.abort) mode = 0;
      else if (mode == 1 && b.pause) mode = 2;
      else if (mode == 2) begin
        if (!b.pause) mode = 1;
      end else begin
        mp = (mp + (mdir ? 2 * W - 1 : 1)) % (2 * W);
        mrem--;
        if (mrem == 0) begin mode = 0; mdone = 1; end
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    cyc_n++;
    @(negedge clk);
    chk("model", outs(), 16'({pat(mp), 3'(mp), mode != 0, mdone, merr}));
  endtask
  task automatic drv(input logic r, s, input logic [7:0] n, input logic d, p, a, l, input logic [3:0] lv);
    rst = r; b.start = s; b.steps = n; b.dir = d; b.pause = p; b.abort = a; b.load = l; b.load_val = lv;
  endtask
  task automatic v(input logic r, s, input logic [7:0] n, input logic d, p, a, l, input logic [3:0] lv,
                   input logic [3:0] q, input logic [2:0] ph, input logic bz, dn, e);
    tbl.push_back('{r, s, n, d, p, a, l, lv, q, ph, bz, dn, e});
  endtask
  task automatic idle_row(input logic [3:0] q, input logic [2:0] ph, input logic bz, dn, e);
    v(1, 0, 0, 0, 0, 0, 0, 0, q, ph, bz, dn, e);
  endtask
  initial begin
    v(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    idle_row(4'b0000, 0, 0, 0, 0);
    v(1, 1, 3, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 0);
    idle_row(4'b0001, 1, 1, 0, 0);
    idle_row(4'b0011, 2, 1, 0, 0);
    idle_row(4'b0111, 3, 0, 1, 0);
    idle_row(4'b0111, 3, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    v(1, 1, 8, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 0);
    idle_row(4'b0001, 1, 1, 0, 0);
    idle_row(4'b0011, 2, 1, 0, 0);
    idle_row(4'b0111, 3, 1, 0, 0);
    idle_row(4'b1111, 4, 1, 0, 0);
    idle_row(4'b1110, 5, 1, 0, 0);
    idle_row(4'b1100, 6, 1, 0, 0);
    idle_row(4'b1000, 7, 1, 0, 0);
    idle_row(4'b0000, 0, 0, 1, 0);
    idle_row(4'b0000, 0, 0, 0, 0);
    v(1, 1, 2, 1, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 0);
    idle_row(4'b1000, 7, 1, 0, 0);
    idle_row(4'b1100, 6, 0, 1, 0);
    idle_row(4'b1100, 6, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 1, 4'b1010, 4'b1100, 6, 0, 0, 1);
    idle_row(4'b1100, 6, 0, 0, 1);
    v(1, 0, 0, 0, 0, 0, 1, 4'b1110, 4'b1110, 5, 0, 0, 0);
    v(1, 1, 4, 0, 0, 0, 1, 4'b0011, 4'b0011, 2, 0, 0, 0);
    idle_row(4'b0011, 2, 0, 0, 0);
    v(1, 1, 0, 0, 0, 0, 0, 0, 4'b0011, 2, 0, 1, 0);
    idle_row(4'b0011, 2, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 1, 4'b1010, 4'b0011, 2, 0, 0, 1);
    v(1, 1, 1, 0, 0, 0, 0, 0, 4'b0011, 2, 1, 0, 0);
    v(1, 1, 5, 1, 0, 0, 1, 4'b1111, 4'b0111, 3, 0, 1, 0);
    idle_row(4'b0111, 3, 0, 0, 0);
    foreach (tbl[i]) begin
      drv(tbl[i].rst, tbl[i].start, tbl[i].steps, tbl[i].dir, tbl[i].pause, tbl[i].abort, tbl[i].load, tbl[i].lv);
      cyc();
      chk($sformatf("vec%0d", i), outs(), 16'({tbl[i].q, tbl[i].ph, tbl[i].busy, tbl[i].done, tbl[i].err}));
    end
    // five forward steps from 1000 with three cycles spent in PAUSE
    drv(1, 0, 0, 0, 0, 0, 1, 4'b1000); cyc();
    chk("preload_1000", outs(), 16'({4'b1000, 3'd7, 1'b0, 1'b0, 1'b0}));
    drv(1, 1, 5, 0, 0, 0, 0, 0); t0 = cyc_n; cyc();
    drv(1, 0, 0, 0, 0, 0, 0, 0); cyc(); cyc();
    b.pause = 1; cyc(); cyc(); b.pause = 0;
    while (!b.done && cyc_n - t0 < 20) cyc();
    chk("pause_done_cycle", 16'(cyc_n - t0), 16'd9);
    chk("pause_final_q", 16'(b.q), 16'b1111);
    // abort after two steps
    drv(1, 0, 0, 0, 0, 0, 1, 4'b0000); cyc();
    drv(1, 1, 6, 0, 0, 0, 0, 0); cyc();
    drv(1, 0, 0, 0, 0, 0, 0, 0); cyc(); cyc();
    b.abort = 1; cyc(); b.abort = 0;
    chk("abort_state", outs(), 16'({4'b0011, 3'd2, 1'b0, 1'b0, 1'b0}));
    repeat (3) begin cyc(); chk("abort_no_done", 16'(b.done), 16'd0); end
    // reset in the middle of a ten-step run
    drv(1, 0, 0, 0, 0, 0, 1, 4'b0000); cyc();
    drv(1, 1, 10, 0, 0, 0, 0, 0); cyc();
    drv(1, 0, 0, 0, 0, 0, 0, 0); repeat (4) cyc();
    chk("pre_rst", outs(), 16'({4'b1111, 3'd4, 1'b1, 1'b0, 1'b0}));
    rst = 0; cyc(); rst = 1;
    chk("mid_rst", outs(), 16'd0);
    repeat (3) begin cyc(); chk("rst_no_done", 16'(b.done), 16'd0); end
    drv(1, 1, 1, 0, 0, 0, 0, 0); cyc();
    drv(1, 0, 0, 0, 0, 0, 0, 0); cyc();
    chk("after_rst_run", outs(), 16'({4'b0001, 3'd1, 1'b0, 1'b1, 1'b0}));
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 199) != 0;
      b.start = $urandom_range(0, 3) == 0;
      b.steps = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      b.dir = 1'($urandom);
      b.pause = $urandom_range(0, 5) == 0;
      b.abort = $urandom_range(0, 24) == 0;
      b.load = $urandom_range(0, 9) == 0;
      b.load_val = $urandom_range(0, 1) ? pat(int'($urandom_range(0, 2 * W - 1))) : 4'($urandom);
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
